// File: rtl/adc_spi_responder.sv
// Device-side SPI responder standing in for the 12-bit, 8-channel serial ADC.
// Optional feature: define ADC_RESP_RAMP_EN to auto-increment the sample read by each completed frame.

module adc_sample_reg #(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld,
  input  logic [SAMPLE_W-1:0] ld_val,
  output logic [SAMPLE_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (ld)   q <= ld_val;
  end
endmodule

module adc_spi_responder #(
  parameter int          FRAME_BITS = 16,
  parameter logic [2:0]  RESET_ADDR = 3'd0,
  parameter logic [11:0] RAMP_STEP  = 12'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        wr_en,
  input  logic [2:0]  wr_chan,
  input  logic [11:0] wr_data,
  output logic [15:0] ast_source_data,
  output logic        ast_source_valid,
  output logic [1:0]  ast_source_error
);
  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 12;
  localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      state;
  logic [2:0]  addr;
  logic [15:0] tx_shift, rx_shift;
  logic [4:0]  bit_cnt;
  logic        overrun;

  logic [NUM_CH-1:0][SAMPLE_W-1:0] sample_q, sample_nxt;
  logic [15:0] rx_word;
  logic        complete;
  logic [2:0]  addr_new;

  assign rx_word  = {rx_shift[14:0], mosi};
  assign complete = (state == SHIFT) && !cs_n && (bit_cnt == LAST_CNT);
  assign addr_new = rx_word[15] ? rx_word[12:10] : addr;
  assign miso     = !cs_n && tx_shift[15];

  // sample_nxt is the post-edge view of each channel, so reloads see write-through and ramp.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                wr_hit, ld;
    logic [SAMPLE_W-1:0] ld_val;
    assign wr_hit = wr_en && (wr_chan == 3'(i));
`ifdef ADC_RESP_RAMP_EN
    logic inc;
    assign inc    = complete && (addr == 3'(i)) && !wr_hit;
    assign ld     = wr_hit || inc;
    assign ld_val = wr_hit ? wr_data : sample_q[i] + RAMP_STEP;
`else
    assign ld     = wr_hit;
    assign ld_val = wr_data;
`endif
    assign sample_nxt[i] = ld ? ld_val : sample_q[i];

    adc_sample_reg #(.SAMPLE_W(SAMPLE_W)) u_smp (
      .clk    (clk),
      .reset_n(reset_n),
      .ld     (ld),
      .ld_val (ld_val),
      .q      (sample_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr             <= RESET_ADDR;
      tx_shift         <= {1'b0, RESET_ADDR, 12'h000};
      rx_shift         <= '0;
      bit_cnt          <= '0;
      overrun          <= 1'b0;
      ast_source_data  <= '0;
      ast_source_valid <= 1'b0;
      ast_source_error <= 2'b00;
    end else begin
      ast_source_valid <= 1'b0;
      case (state)
        IDLE: if (!cs_n) begin
          rx_shift <= rx_word;
          tx_shift <= {tx_shift[14:0], 1'b0};
          bit_cnt  <= 5'd1;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (cs_n) begin
            ast_source_valid <= 1'b1;
            ast_source_error <= 2'b01;
            ast_source_data  <= rx_shift;
            tx_shift         <= {1'b0, addr, sample_nxt[addr]};
            state            <= IDLE;
          end else if (complete) begin
            rx_shift         <= rx_word;
            bit_cnt          <= bit_cnt + 5'd1;
            ast_source_valid <= 1'b1;
            ast_source_error <= 2'b00;
            ast_source_data  <= rx_word;
            addr             <= addr_new;
            tx_shift         <= {1'b0, addr_new, sample_nxt[addr_new]};
            state            <= HOLD;
          end else begin
            rx_shift <= rx_word;
            tx_shift <= {tx_shift[14:0], 1'b0};
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        HOLD: begin
          // tx_shift[15] is zero after reload, so miso stays low while cs_n lingers.
          if (!cs_n) overrun <= 1'b1;
          else begin
            if (overrun) begin
              ast_source_valid <= 1'b1;
              ast_source_error <= 2'b10;
            end
            overrun <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder against a frame-level model of channels, address and pending response.

module tb_adc_spi_responder;
  localparam logic [11:0] RAMP_STEP = 12'd1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_n, mosi, miso;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [11:0] wr_data;
  logic [15:0] ast_source_data;
  logic        ast_source_valid;
  logic [1:0]  ast_source_error;

  adc_spi_responder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cs_n            (cs_n),
    .mosi            (mosi),
    .miso            (miso),
    .wr_en           (wr_en),
    .wr_chan         (wr_chan),
    .wr_data         (wr_data),
    .ast_source_data (ast_source_data),
    .ast_source_valid(ast_source_valid),
    .ast_source_error(ast_source_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: channel contents, selected address, word the next frame returns
  logic [11:0] m_smp [8];
  logic [2:0]  m_addr;
  logic [15:0] m_resp;

  logic [17:0] mon_q[$];
  always @(negedge clk)
    if (ast_source_valid) mon_q.push_back({ast_source_error, ast_source_data});

  task automatic wr(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_chan = ch; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_smp[ch] = d;
  endtask

  // n cycles with cs_n low; optional write on edge e (n+1 = the cs_n-high edge)
  task automatic frame(input logic [15:0] w, input int n, input int e,
                       input logic [2:0] wc, input logic [11:0] wd, output logic [15:0] got);
    logic [15:0] resp;
    logic [15:0] mask;
    resp = m_resp;
    got  = '0;
    mon_q.delete();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cs_n = 1'b0;
      mosi = (k <= 16) ? w[16-k] : 1'b0;
      wr_en = (k == e); wr_chan = wc; wr_data = wd;
      #1;
      if (k <= 16) got[16-k] = miso;
      else chk("miso_hold", {31'b0, miso}, 32'd0);
    end
    @(negedge clk);
    cs_n = 1'b1; mosi = 1'b0;
    wr_en = (e == n + 1); wr_chan = wc; wr_data = wd;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);

    if (n >= 16) begin
      if (e >= 1 && e <= 16) m_smp[wc] = wd;
`ifdef ADC_RESP_RAMP_EN
      if (!(e == 16 && wc == m_addr)) m_smp[m_addr] = m_smp[m_addr] + RAMP_STEP;
`endif
      if (w[15]) m_addr = w[12:10];
      m_resp = {1'b0, m_addr, m_smp[m_addr]};
      if (e > 16) m_smp[wc] = wd;
      chk("miso_word", {16'b0, got}, {16'b0, resp});
      chk("strobe_cnt", mon_q.size(), (n > 16) ? 2 : 1);
      if (mon_q.size() >= 1) chk("cmpl", {14'b0, mon_q[0]}, {14'b0, 2'b00, w});
      if (n > 16 && mon_q.size() >= 2) chk("ovrun", {14'b0, mon_q[1]}, {14'b0, 2'b10, w});
    end else begin
      if (e >= 1) m_smp[wc] = wd;
      m_resp = {1'b0, m_addr, m_smp[m_addr]};
      mask = 16'((32'd1 << n) - 1);
      chk("miso_part", {16'b0, got >> (16 - n)}, {16'b0, resp >> (16 - n)});
      chk("strobe_cnt", mon_q.size(), 1);
      if (mon_q.size() >= 1) begin
        chk("abort_err", {30'b0, mon_q[0][17:16]}, 32'd1);
        chk("abort_data", {16'b0, mon_q[0][15:0] & mask}, {16'b0, (w >> (16 - n)) & mask});
      end
    end
  endtask

  initial begin
    logic [15:0] got, w;
    int n, e;
    reset_n = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wr_en = 1'b0; wr_chan = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) m_smp[i] = '0;
    m_addr = 3'd0;
    m_resp = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_valid", {31'b0, ast_source_valid}, 32'd0);
    chk("rst_data", {16'b0, ast_source_data}, 32'd0);
    chk("rst_err", {30'b0, ast_source_error}, 32'd0);

    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("first_resp", {16'b0, got}, 32'h0000);

    wr(3'd5, 12'hABC);
    frame(16'h9400, 16, 0, 3'd0, 12'h0, got);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("sel5_resp", {16'b0, got}, 32'h5ABC);

    frame(16'h8000, 16, 0, 3'd0, 12'h0, got);
    frame(16'h9400, 7, 0, 3'd0, 12'h0, got);
    chk("abort_addr", {29'b0, m_addr}, 32'd0);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("after_abort_hi", {28'b0, got[15:12]}, 32'd0);

    frame(16'h0000, 18, 0, 3'd0, 12'h0, got);

    frame(16'h9400, 16, 16, 3'd5, 12'h123, got);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("wr_through", {16'b0, got}, 32'h5123);

`ifdef ADC_RESP_RAMP_EN
    wr(3'd2, 12'hFFF);
    frame(16'h8800, 16, 0, 3'd0, 12'h0, got);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("ramp0", {16'b0, got}, 32'h2FFF);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("ramp1", {16'b0, got}, 32'h2000);
    frame(16'h0000, 16, 0, 3'd0, 12'h0, got);
    chk("ramp2", {16'b0, got}, 32'h2001);
`endif

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) wr(3'($urandom_range(0, 7)), 12'($urandom));
      w = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(1, 15);
        1:       n = $urandom_range(17, 20);
        default: n = 16;
      endcase
      e = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, n + 1);
      frame(w, n, e, 3'($urandom_range(0, 7)), 12'($urandom), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
